// File: rtl/cla_vector_checker_if.sv
// ---------------------------------------------------------------------------
// cla_vector_checker_if
// Bus between the vector checker (initiator) and the registered
// carry-lookahead adder under test.
//   load : adder capture strobe (initiator -> adder)
//   a, b : WIDTH-bit operands    (initiator -> adder)
//   Cin  : carry-in              (initiator -> adder)
//   Q    : WIDTH+1-bit result    (adder -> initiator)
// Modports: master = checker side, slave = adder side.
// ---------------------------------------------------------------------------
interface cla_vector_checker_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Cin;
  logic [WIDTH:0]   Q;

  modport master (output load, a, b, Cin, input Q);
  modport slave  (input load, a, b, Cin, output Q);
endinterface

// File: rtl/cla_vector_checker.sv
// ---------------------------------------------------------------------------
// cla_vector_checker
// Exhaustive self-checking driver for a registered WIDTH-bit carry-lookahead
// adder. On start it issues every {a, b, Cin} combination, waits LAT cycles
// for the registered result, compares it with a locally computed sum, and
// reports a saturating mismatch count, the first failing vector index and a
// pass flag.
//
// Parameters:
//   WIDTH : operand width (result is WIDTH+1 bits)
//   LAT   : adder latency in cycles, 1..15
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a sweep (honoured only in IDLE or DONE)
//   bus               : adder interface, master side (load/a/b/Cin out, Q in)
//   busy              : sweep in progress
//   done              : sweep complete, held until the next start
//   pass              : no mismatches (valid with done)
//   err_count         : mismatch count, saturates at 16'hFFFF
//   first_fail_idx    : vector index of the first mismatch
//   first_fail_valid  : first_fail_idx holds a captured index
// ---------------------------------------------------------------------------
module cla_vector_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  cla_vector_checker_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [2*WIDTH:0]     first_fail_idx,
  output logic                 first_fail_valid
);

  localparam int IDX_W = 2 * WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       wait_cnt;
  logic [WIDTH:0]   exp_q;

  // Next vector to issue: index 0 on a (re)start, idx+1 after a CHECK.
  logic [IDX_W-1:0] nxt_idx;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_b;
  logic             nxt_cin;
  logic [WIDTH:0]   nxt_exp;
  logic             mismatch;
  logic [15:0]      err_next;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_idx = '0;
    if (state == S_CHECK) begin
      nxt_idx = idx + 1'b1;
    end
    nxt_a   = nxt_idx[2*WIDTH:WIDTH+1];
    nxt_b   = nxt_idx[WIDTH:1];
    nxt_cin = nxt_idx[0];
    // Full WIDTH+1-bit sum so the carry-out is checked too.
    nxt_exp = {1'b0, nxt_a} + {1'b0, nxt_b} + {{WIDTH{1'b0}}, nxt_cin};

    mismatch = (state == S_CHECK) && (bus.Q != exp_q);
    err_next = err_count;
    if (mismatch && (err_count != 16'hFFFF)) begin
      err_next = err_count + 16'd1;
    end
  end

  // All outputs are registers, so an asynchronous reset clears every one of
  // them immediately without waiting for a clock edge.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      idx              <= '0;
      wait_cnt         <= '0;
      exp_q            <= '0;
      bus.load         <= 1'b0;
      bus.a            <= '0;
      bus.b            <= '0;
      bus.Cin          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_DRIVE;
            idx              <= '0;
            exp_q            <= nxt_exp;
            bus.load         <= 1'b1;
            bus.a            <= nxt_a;
            bus.b            <= nxt_b;
            bus.Cin          <= nxt_cin;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end

        S_DRIVE: begin
          // The adder samples load=1 on this edge; operands stay held.
          bus.load <= 1'b0;
          wait_cnt <= 4'(LAT - 1);
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_idx   <= idx;
            first_fail_valid <= 1'b1;
          end
          if (idx == {IDX_W{1'b1}}) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            state    <= S_DRIVE;
            idx      <= nxt_idx;
            exp_q    <= nxt_exp;
            bus.load <= 1'b1;
            bus.a    <= nxt_a;
            bus.b    <= nxt_b;
            bus.Cin  <= nxt_cin;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_cla_vector_checker
// Drives two checker instances against behavioural adder models:
//   dut1 : LAT=1 with a one-register adder that can inject faults
//   dut2 : LAT=2 with a two-register adder (always correct)
// Sweep outcomes come from a table of hand-computed expectations; reset
// mid-sweep, the LAT=2 sweep and result hold are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_cla_vector_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start2;

  always #5 clk = ~clk;

  cla_vector_checker_if #(.WIDTH(4)) bus1 ();
  cla_vector_checker_if #(.WIDTH(4)) bus2 ();

  logic        d1_busy, d1_done, d1_pass, d1_ffv;
  logic [15:0] d1_err;
  logic [8:0]  d1_ffi;
  logic        d2_busy, d2_done, d2_pass, d2_ffv;
  logic [15:0] d2_err;
  logic [8:0]  d2_ffi;

  cla_vector_checker #(.WIDTH(4), .LAT(1)) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start1),
    .bus              (bus1),
    .busy             (d1_busy),
    .done             (d1_done),
    .pass             (d1_pass),
    .err_count        (d1_err),
    .first_fail_idx   (d1_ffi),
    .first_fail_valid (d1_ffv)
  );

  cla_vector_checker #(.WIDTH(4), .LAT(2)) dut2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start2),
    .bus              (bus2),
    .busy             (d2_busy),
    .done             (d2_done),
    .pass             (d2_pass),
    .err_count        (d2_err),
    .first_fail_idx   (d2_ffi),
    .first_fail_valid (d2_ffv)
  );

  // Fault modes: 0 correct, 1 Q[4] stuck at 0, 2 wrong only at a=9,b=10,Cin=1.
  int fault_mode;

  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input int mode);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, c};
    if (mode == 1) s[4] = 1'b0;
    if (mode == 2 && a == 4'd9 && b == 4'd10 && c == 1'b1) s = s ^ 5'h01;
    return s;
  endfunction

  // Latency-1 adder.
  always @(posedge clk) begin
    if (bus1.load) bus1.Q <= adder_model(bus1.a, bus1.b, bus1.Cin, fault_mode);
  end

  // Latency-2 adder: capture register followed by an output register.
  logic [4:0] stage2;
  always @(posedge clk) begin
    if (bus2.load) stage2 <= adder_model(bus2.a, bus2.b, bus2.Cin, 0);
    bus2.Q <= stage2;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dut1"}, {bus1.load, bus1.a, bus1.b, bus1.Cin, d1_busy, d1_done,
                            d1_pass, d1_err, d1_ffi, d1_ffv}, 64'd0);
    check({name, "_dut2"}, {bus2.load, bus2.a, bus2.b, bus2.Cin, d2_busy, d2_done,
                            d2_pass, d2_err, d2_ffi, d2_ffv}, 64'd0);
  endtask

  // Starts a sweep on dut1 or dut2 and counts edges until done is seen.
  // With pester set, start is re-asserted periodically while busy.
  task automatic run_sweep(input int which, input bit pester, output int cycles);
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    check("start_load",  (which == 1) ? bus1.load : bus2.load, 1);
    check("start_busy",  (which == 1) ? d1_busy : d2_busy, 1);
    check("start_done",  (which == 1) ? d1_done : d2_done, 0);
    check("start_err",   (which == 1) ? d1_err : d2_err, 0);
    check("start_ffv",   (which == 1) ? d1_ffv : d2_ffv, 0);
    cycles = 0;
    while (cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        check("load_drop", (which == 1) ? bus1.load : bus2.load, 0);
        check("busy_hold", (which == 1) ? d1_busy : d2_busy, 1);
      end
      if ((which == 1) ? d1_done : d2_done) break;
      if (pester && (cycles % 50 == 10) && cycles < 1400) begin
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
      end else begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
    end
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  typedef struct {
    int          mode;
    bit          pester;
    int          exp_cycles;
    logic [15:0] exp_err;
    bit          exp_ffv;
    logic [8:0]  exp_ffi;
    bit          exp_pass;
  } sweep_vec_t;

  sweep_vec_t vecs[4];
  int cyc;

  initial begin
    vecs[0] = '{mode: 0, pester: 1'b1, exp_cycles: 1536, exp_err: 16'd0,
                exp_ffv: 1'b0, exp_ffi: 9'd0,     exp_pass: 1'b1};
    vecs[1] = '{mode: 1, pester: 1'b0, exp_cycles: 1536, exp_err: 16'd256,
                exp_ffv: 1'b1, exp_ffi: 9'd31,    exp_pass: 1'b0};
    vecs[2] = '{mode: 2, pester: 1'b0, exp_cycles: 1536, exp_err: 16'd1,
                exp_ffv: 1'b1, exp_ffi: 9'h135,   exp_pass: 1'b0};
    vecs[3] = '{mode: 0, pester: 1'b1, exp_cycles: 1536, exp_err: 16'd0,
                exp_ffv: 1'b0, exp_ffi: 9'd0,     exp_pass: 1'b1};

    rst_n      = 1'b0;
    start1     = 1'b0;
    start2     = 1'b0;
    fault_mode = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle");

    for (int i = 0; i < 4; i++) begin
      fault_mode = vecs[i].mode;
      run_sweep(1, vecs[i].pester, cyc);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cycles);
      check($sformatf("v%0d_done", i),   d1_done, 1);
      check($sformatf("v%0d_busy", i),   d1_busy, 0);
      check($sformatf("v%0d_err", i),    d1_err, vecs[i].exp_err);
      check($sformatf("v%0d_ffv", i),    d1_ffv, vecs[i].exp_ffv);
      if (vecs[i].exp_ffv) check($sformatf("v%0d_ffi", i), d1_ffi, vecs[i].exp_ffi);
      check($sformatf("v%0d_pass", i),   d1_pass, vecs[i].exp_pass);
    end

    // Results hold in DONE without a new start.
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", d1_done, 1);
    check("hold_pass", d1_pass, 1);
    check("hold_load", bus1.load, 0);

    // Reset mid-sweep: stuck-Q[4] model, reset after edge N+100.
    fault_mode = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    // Edge N+100 enters WAIT of vector 33: a=1, b=0, Cin=1; only vector 31 failed.
    check("mid_a",    bus1.a, 4'd1);
    check("mid_b",    bus1.b, 4'd0);
    check("mid_cin",  bus1.Cin, 1);
    check("mid_load", bus1.load, 0);
    check("mid_err",  d1_err, 16'd1);
    check("mid_ffv",  d1_ffv, 1);
    check("mid_ffi",  d1_ffi, 9'd31);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume_busy", d1_busy, 0);
    check("no_resume_load", bus1.load, 0);
    fault_mode = 0;
    run_sweep(1, 1'b0, cyc);
    check("post_rst_cycles", cyc, 1536);
    check("post_rst_pass",   d1_pass, 1);
    check("post_rst_err",    d1_err, 16'd0);

    // LAT=2 sweep against the two-register adder.
    run_sweep(2, 1'b0, cyc);
    check("lat2_cycles", cyc, 2048);
    check("lat2_done",   d2_done, 1);
    check("lat2_pass",   d2_pass, 1);
    check("lat2_err",    d2_err, 16'd0);
    check("lat2_ffv",    d2_ffv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
